// File: rtl/cu_sequencer.sv
// Multi-cycle sequencer for the LEGv8 control unit: shared state register, sub-CU select,
// fetch/IR/status/PC strobes, memory-wait timeout and retired-instruction counter.
//
// state | meaning
// FETCH | request instruction, load IR and PC+4 when memory is ready
// EXEC0 | first execute cycle, class-specific sub-CU drives the control word
// EXEC1 | second cycle of CBZ/CBNZ/BL, resolves the PC update
// MEM   | waiting on data memory for LDUR/STUR
// FAULT | sticky error, strobes quiet, left only by reset
module cu_sequencer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_run,
   input  logic [10:0]      i_opcode,
   input  logic [3:0]       i_status,
   input  logic             i_mem_ready,
   output logic [3:0]       o_state,
   output logic [1:0]       o_cu_sel,
   output logic             o_mem_req,
   output logic             o_ir_load,
   output logic             o_status_load,
   output logic [1:0]       o_pc_fs,
   output logic             o_fault,
   output logic [CNT_W-1:0] o_retire_count
);
   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      ST_FETCH = 4'd0,
      ST_EXEC0 = 4'd1,
      ST_EXEC1 = 4'd2,
      ST_MEM   = 4'd3,
      ST_FAULT = 4'd15
   } state_t;

   typedef enum logic [2:0] {
      OP_ALU, OP_CBZ, OP_CBNZ, OP_B, OP_BL, OP_LDUR, OP_STUR, OP_ILL
   } op_t;

   state_t            r_state;
   state_t            w_next;
   op_t               w_op;
   logic [WAIT_W-1:0] r_wait;
   logic              r_fault;
   logic [CNT_W-1:0]  r_retire;
   logic [1:0]        w_cu_sel;
   logic [1:0]        w_pc_fs;
   logic              w_mem_req;
   logic              w_ir_load;
   logic              w_status_load;
   logic              w_waiting;
   logic              w_timeout;
   logic              w_z;

   assign w_z       = i_status[2];
   assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == WAIT_LAST) && !i_mem_ready;

   always_comb begin
      if (i_opcode[10:3] == 8'b10110100)      w_op = OP_CBZ;
      else if (i_opcode[10:3] == 8'b10110101) w_op = OP_CBNZ;
      else if (i_opcode[10:5] == 6'b000101)   w_op = OP_B;
      else if (i_opcode[10:5] == 6'b100101)   w_op = OP_BL;
      else if (i_opcode == 11'b11111000010)   w_op = OP_LDUR;
      else if (i_opcode == 11'b11111000000)   w_op = OP_STUR;
      else if (i_opcode == 11'h000)           w_op = OP_ILL;
      else                                    w_op = OP_ALU;
   end

   always_comb begin
      w_next        = r_state;
      w_cu_sel      = 2'b11;
      w_pc_fs       = 2'b00;
      w_mem_req     = 1'b0;
      w_ir_load     = 1'b0;
      w_status_load = 1'b0;
      w_waiting     = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_mem_req = i_run;
            if (i_run && i_mem_ready) begin
               w_ir_load = 1'b1;
               w_pc_fs   = 2'b01;
               w_next    = ST_EXEC0;
            end else if (i_run) begin
               w_waiting = 1'b1;
               if (w_timeout) w_next = ST_FAULT;
            end
         end
         ST_EXEC0: begin
            case (w_op)
               OP_ALU: begin
                  w_cu_sel = 2'b00;
                  w_next   = ST_FETCH;
               end
               OP_CBZ, OP_CBNZ: begin
                  w_cu_sel      = 2'b01;
                  w_status_load = 1'b1;
                  w_next        = ST_EXEC1;
               end
               OP_B: begin
                  w_cu_sel = 2'b01;
                  w_pc_fs  = 2'b11;
                  w_next   = ST_FETCH;
               end
               OP_BL: begin
                  w_cu_sel = 2'b01;
                  w_next   = ST_EXEC1;
               end
               OP_LDUR, OP_STUR: begin
                  w_cu_sel  = 2'b10;
                  w_mem_req = 1'b1;
                  w_next    = i_mem_ready ? ST_FETCH : ST_MEM;
               end
               default: w_next = ST_FAULT;
            endcase
         end
         ST_EXEC1: begin
            w_cu_sel = 2'b01;
            w_next   = ST_FETCH;
            case (w_op)
               OP_CBZ:  w_pc_fs = w_z ? 2'b11 : 2'b00;
               OP_CBNZ: w_pc_fs = w_z ? 2'b00 : 2'b11;
               OP_BL:   w_pc_fs = 2'b11;
               default: w_pc_fs = 2'b00;
            endcase
         end
         ST_MEM: begin
            w_cu_sel  = 2'b10;
            w_mem_req = 1'b1;
            if (i_mem_ready) begin
               w_next = ST_FETCH;
            end else begin
               w_waiting = 1'b1;
               if (w_timeout) w_next = ST_FAULT;
            end
         end
         ST_FAULT: w_next = ST_FAULT;
         default:  w_next = ST_FAULT;
      endcase
   end

   // Strobes are forced quiet while reset is asserted, even though state already reads FETCH.
   assign o_cu_sel       = rst_n ? w_cu_sel : 2'b11;
   assign o_pc_fs        = rst_n ? w_pc_fs : 2'b00;
   assign o_mem_req      = rst_n & w_mem_req;
   assign o_ir_load      = rst_n & w_ir_load;
   assign o_status_load  = rst_n & w_status_load;
   assign o_state        = r_state;
   assign o_fault        = r_fault;
   assign o_retire_count = r_retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_FETCH;
         r_fault  <= 1'b0;
         r_retire <= '0;
         r_wait   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == ST_FAULT) r_fault <= 1'b1;
         if ((w_next == ST_FETCH) &&
             ((r_state == ST_EXEC0) || (r_state == ST_EXEC1) || (r_state == ST_MEM)))
            r_retire <= r_retire + 1'b1;
         r_wait <= (w_waiting && (w_next == r_state)) ? r_wait + 1'b1 : '0;
      end
   end

endmodule
